// File: rtl/rx_comma_aligner_if.sv
// Bundles the serial receive input and the aligned symbol output of the comma aligner.
// Latency: none, this is wiring only.
// Backpressure: none, the receive path is free-running at one bit per clock.
interface rx_comma_aligner_if;
    logic       data_in;
    logic       RXIDLE;
    logic [9:0] data_out;
    logic       SYMBOL_CLK;
    logic       RXVALID;
    logic       COMMA_DET;

    // Receiver side: supplies bits and idle, consumes aligned symbols.
    modport master (
        output data_in,
        output RXIDLE,
        input  data_out,
        input  SYMBOL_CLK,
        input  RXVALID,
        input  COMMA_DET
    );

    // Aligner side.
    modport slave (
        input  data_in,
        input  RXIDLE,
        output data_out,
        output SYMBOL_CLK,
        output RXVALID,
        output COMMA_DET
    );
endinterface

// File: rtl/rx_comma_aligner.sv
// Serial-to-parallel front end: hunts the K28.5 comma, confirms alignment, emits 10-bit symbols.
// Latency: a symbol is registered on the edge sampling its 10th bit and is visible the next cycle.
// Backpressure: none; one bit per clock is always consumed, and RXIDLE flushes alignment.
module rx_comma_aligner #(
    parameter int         CONFIRM_COMMAS  = 2,
    parameter int         CONFIRM_TIMEOUT = 16,
    parameter logic [9:0] K285_NEG        = 10'b0101111100,
    parameter logic [9:0] K285_POS        = 10'b1010000011
) (
    input logic               clock,
    input logic               Reset,
    rx_comma_aligner_if.slave rx
);

    typedef enum logic [1:0] {
        HUNT,
        CONFIRM,
        LOCKED
    } state_t;

    localparam logic [3:0] CC = 4'(CONFIRM_COMMAS);
    localparam logic [7:0] CT = 8'(CONFIRM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] sh;
    logic [9:0] win;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] ccnt;
    logic [3:0] ccnt_nxt;
    logic [3:0] ccnt_inc;
    logic [7:0] tcnt;
    logic [7:0] tcnt_nxt;
    logic [7:0] tcnt_inc;
    logic       comma;
    logic       boundary;
    logic       emit;
    logic       rxvalid_nxt;

    // The newest bit lands at the top so the first-received bit of a symbol ends up in bit 0.
    assign win      = {rx.data_in, sh[9:1]};
    assign comma    = (win == K285_NEG) || (win == K285_POS);
    assign boundary = (cnt == 4'd9);

    // Next-state, counter updates and symbol emit decision.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ccnt_nxt    = ccnt;
        tcnt_nxt    = tcnt;
        emit        = 1'b0;
        rxvalid_nxt = rx.RXVALID;
        ccnt_inc    = ccnt + 4'd1;
        tcnt_inc    = tcnt + 8'd1;
        unique case (state)
            HUNT: begin
                cnt_nxt = 4'd0;
                if (comma) begin
                    emit     = 1'b1;
                    ccnt_nxt = 4'd1;
                    tcnt_nxt = 8'd0;
                    if (CC == 4'd1) begin
                        state_nxt   = LOCKED;
                        rxvalid_nxt = 1'b1;
                    end else begin
                        state_nxt = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (comma && !boundary) begin
                    // A comma off the expected phase becomes the new anchor.
                    emit     = 1'b1;
                    cnt_nxt  = 4'd0;
                    ccnt_nxt = 4'd1;
                    tcnt_nxt = 8'd0;
                end else if (boundary) begin
                    emit    = 1'b1;
                    cnt_nxt = 4'd0;
                    if (comma) begin
                        ccnt_nxt = ccnt_inc;
                        if (ccnt_inc >= CC) begin
                            state_nxt   = LOCKED;
                            rxvalid_nxt = 1'b1;
                        end
                    end else begin
                        tcnt_nxt = tcnt_inc;
                        if (tcnt_inc >= CT) begin
                            state_nxt = HUNT;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            LOCKED: begin
                if (comma && !boundary) begin
                    // Lost phase: drop valid and re-confirm around the new comma.
                    emit        = 1'b1;
                    cnt_nxt     = 4'd0;
                    ccnt_nxt    = 4'd1;
                    tcnt_nxt    = 8'd0;
                    state_nxt   = CONFIRM;
                    rxvalid_nxt = 1'b0;
                end else if (boundary) begin
                    emit    = 1'b1;
                    cnt_nxt = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // State register; idle restarts the hunt just like reset.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state <= HUNT;
        end else if (rx.RXIDLE) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift register, counters and registered outputs; idle keeps the last symbol on data_out.
    always_ff @(posedge clock) begin
        if (Reset) begin
            sh            <= 10'd0;
            cnt           <= 4'd0;
            ccnt          <= 4'd0;
            tcnt          <= 8'd0;
            rx.data_out   <= 10'd0;
            rx.SYMBOL_CLK <= 1'b0;
            rx.RXVALID    <= 1'b0;
            rx.COMMA_DET  <= 1'b0;
        end else if (rx.RXIDLE) begin
            sh            <= 10'd0;
            cnt           <= 4'd0;
            ccnt          <= 4'd0;
            tcnt          <= 8'd0;
            rx.SYMBOL_CLK <= 1'b0;
            rx.RXVALID    <= 1'b0;
            rx.COMMA_DET  <= 1'b0;
        end else begin
            sh            <= win;
            cnt           <= cnt_nxt;
            ccnt          <= ccnt_nxt;
            tcnt          <= tcnt_nxt;
            rx.SYMBOL_CLK <= emit;
            rx.COMMA_DET  <= emit && comma;
            rx.RXVALID    <= rxvalid_nxt;
            if (emit) begin
                rx.data_out <= win;
            end
        end
    end

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Directed test-plan steps followed by random bit streams, every cycle compared to a reference model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: none; the bench drives one bit per clock.
module tb_rx_comma_aligner;

    localparam logic [9:0] K_NEG = 10'h17C;
    localparam logic [9:0] K_POS = 10'h283;
    localparam logic [9:0] D215  = 10'h2AA;
    localparam int         CC    = 2;
    localparam int         CT    = 16;

    logic clock = 1'b0;
    logic Reset = 1'b1;

    rx_comma_aligner_if bus ();

    rx_comma_aligner #(
        .CONFIRM_COMMAS (CC),
        .CONFIRM_TIMEOUT(CT)
    ) dut (
        .clock(clock),
        .Reset(Reset),
        .rx   (bus.slave)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: bits received since the last reset/idle, alignment anchor as a bit index.
    bit         hist[$];
    int         m_mode;     // 0 hunting, 1 confirming, 2 locked
    int         m_nb;       // bits received since restart
    int         m_anc;      // bit index of the last anchoring comma
    int         m_cc;
    int         m_tc;
    logic [9:0] m_dout;
    logic       m_sym;
    logic       m_det;
    logic       m_valid;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic idle, input logic d);
        logic [9:0] w;
        logic       cm;
        logic       bnd;
        logic       emit;
        if (r || idle) begin
            hist.delete();
            m_mode  = 0;
            m_nb    = 0;
            m_cc    = 0;
            m_tc    = 0;
            m_sym   = 1'b0;
            m_det   = 1'b0;
            m_valid = 1'b0;
            if (r) m_dout = 10'd0;
        end else begin
            hist.push_back(d);
            if (hist.size() > 10) void'(hist.pop_front());
            m_nb++;
            // Last ten bits, oldest in bit 0; missing history reads as zero.
            w = 10'd0;
            for (int i = 0; i < hist.size(); i++) w[10 - hist.size() + i] = hist[i];
            cm   = (w == K_NEG) || (w == K_POS);
            bnd  = (m_mode != 0) && (((m_nb - m_anc) % 10) == 0);
            emit = 1'b0;
            if (cm && !bnd) begin
                emit   = 1'b1;
                m_anc  = m_nb;
                m_cc   = 1;
                m_tc   = 0;
                m_mode = (m_mode == 0 && CC == 1) ? 2 : 1;
            end else if (bnd) begin
                emit = 1'b1;
                if (m_mode == 1) begin
                    if (cm) begin
                        m_cc++;
                        if (m_cc >= CC) m_mode = 2;
                    end else begin
                        m_tc++;
                        if (m_tc >= CT) m_mode = 0;
                    end
                end
            end
            m_sym   = emit;
            m_det   = emit && cm;
            m_valid = (m_mode == 2);
            if (emit) m_dout = w;
        end
    endtask

    task automatic step(input logic r, input logic idle, input logic d);
        Reset       = r;
        bus.RXIDLE  = idle;
        bus.data_in = d;
        @(posedge clock);
        #1;
        model(r, idle, d);
        chk("m_dout",  bus.data_out, m_dout);
        chk("m_sym",   {9'd0, bus.SYMBOL_CLK}, {9'd0, m_sym});
        chk("m_det",   {9'd0, bus.COMMA_DET},  {9'd0, m_det});
        chk("m_valid", {9'd0, bus.RXVALID},    {9'd0, m_valid});
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, s[i]);
    endtask

    initial begin
        int pulses;
        int r;
        int n;
        logic [9:0] sym;
        bus.data_in = 1'b0;
        bus.RXIDLE  = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_dout",  bus.data_out, 10'h000);
        chk("rst_sym",   {9'd0, bus.SYMBOL_CLK}, 10'd0);
        chk("rst_valid", {9'd0, bus.RXVALID}, 10'd0);
        chk("rst_det",   {9'd0, bus.COMMA_DET}, 10'd0);

        // Junk bits then the first comma.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        send_sym(K_NEG);
        chk("c1_sym",   {9'd0, bus.SYMBOL_CLK}, 10'd1);
        chk("c1_dout",  bus.data_out, 10'h17C);
        chk("c1_det",   {9'd0, bus.COMMA_DET}, 10'd1);
        chk("c1_valid", {9'd0, bus.RXVALID}, 10'd0);

        // Second aligned comma locks; data follows exactly one symbol later.
        send_sym(K_POS);
        chk("c2_dout",  bus.data_out, 10'h283);
        chk("c2_valid", {9'd0, bus.RXVALID}, 10'd1);
        sym = D215;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, sym[i]);
            chk("d_strobe_phase", {9'd0, bus.SYMBOL_CLK}, (i == 9) ? 10'd1 : 10'd0);
        end
        chk("d_dout", bus.data_out, 10'h2AA);
        chk("d_det",  {9'd0, bus.COMMA_DET}, 10'd0);

        // Slip by four bits while locked.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        send_sym(K_NEG);
        chk("slip_valid", {9'd0, bus.RXVALID}, 10'd0);
        chk("slip_dout",  bus.data_out, 10'h17C);
        chk("slip_sym",   {9'd0, bus.SYMBOL_CLK}, 10'd1);
        send_sym(K_POS);
        chk("relock_valid", {9'd0, bus.RXVALID}, 10'd1);

        // Confirm timeout: re-anchor, then 16 aligned non-comma symbols.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        send_sym(K_NEG);
        chk("to_entry_valid", {9'd0, bus.RXVALID}, 10'd0);
        pulses = 0;
        for (int k = 0; k < CT; k++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 1'b0, sym[i]);
                if (bus.SYMBOL_CLK) pulses++;
            end
        end
        chk("to_pulses", 10'(pulses), 10'(CT));
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 1'b0, sym[i]);
                if (bus.SYMBOL_CLK) pulses++;
            end
        end
        chk("hunt_no_pulses", 10'(pulses), 10'd0);

        // Idle mid-symbol while locked.
        send_sym(K_NEG);
        send_sym(K_POS);
        chk("idle_pre_valid", {9'd0, bus.RXVALID}, 10'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, sym[i]);
        step(1'b0, 1'b1, sym[5]);
        chk("idle_valid", {9'd0, bus.RXVALID}, 10'd0);
        chk("idle_sym",   {9'd0, bus.SYMBOL_CLK}, 10'd0);
        for (int i = 6; i < 10; i++) begin
            step(1'b0, 1'b0, sym[i]);
            chk("idle_old_bnd", {9'd0, bus.SYMBOL_CLK}, 10'd0);
        end
        send_sym(K_NEG);
        chk("idle_c1_sym",   {9'd0, bus.SYMBOL_CLK}, 10'd1);
        chk("idle_c1_valid", {9'd0, bus.RXVALID}, 10'd0);
        send_sym(K_POS);
        chk("idle_c2_valid", {9'd0, bus.RXVALID}, 10'd1);

        // Reset on a completing symbol, then a comma suffix must not lock.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, sym[i]);
        step(1'b1, 1'b0, sym[9]);
        chk("rst2_sym",   {9'd0, bus.SYMBOL_CLK}, 10'd0);
        chk("rst2_valid", {9'd0, bus.RXVALID}, 10'd0);
        chk("rst2_dout",  bus.data_out, 10'h000);
        sym = K_NEG;
        for (int i = 3; i < 10; i++) begin
            step(1'b0, 1'b0, sym[i]);
            chk("suffix_sym", {9'd0, bus.SYMBOL_CLK}, 10'd0);
        end

        // Random mix of commas, data, raw bits, idle and reset.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                send_sym(($urandom_range(0, 1) == 1) ? K_NEG : K_POS);
            end else if (r < 38) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            end else if (r < 40) begin
                step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            end else if (r < 60) begin
                send_sym(D215);
            end else begin
                n = $urandom_range(1, 12);
                for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
